// File: rtl/div_unit.sv
// div_unit: iterative 32-bit radix-2 restoring divider for the EX stage.
// Accepts DIV/DIVU operands from IDLE, performs one restoring step per
// cycle, and holds the pipeline through stallreq until the packed
// {remainder, quotient} result is ready. Divide-by-zero yields 0/0 and an
// in-flight operation can be annulled.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div,
    input  logic [WIDTH-1:0]     opdata1,
    input  logic [WIDTH-1:0]     opdata2,
    input  logic                 start,
    input  logic                 annul,
    output logic [2*WIDTH-1:0]   result,
    output logic                 ready,
    output logic                 stallreq
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BYZERO = 2'd1;
    localparam logic [1:0] ST_ON     = 2'd2;
    localparam logic [1:0] ST_END    = 2'd3;

    localparam logic [5:0] CNT_DONE  = 6'(WIDTH);

    logic [1:0]           state_reg,    state_next;
    logic [5:0]           cnt_reg,      cnt_next;
    logic [2*WIDTH:0]     dividend_reg, dividend_next;
    logic [WIDTH-1:0]     divisor_reg,  divisor_next;
    logic                 signed_reg,   signed_next;
    logic                 sign1_reg,    sign1_next;
    logic                 sign2_reg,    sign2_next;
    logic [2*WIDTH-1:0]   result_reg,   result_next;
    logic                 ready_reg,    ready_next;

    // Operand magnitudes: negative operands in signed mode are replaced by
    // their two's-complement magnitude. 0x80000000 maps to itself, which is
    // the correct unsigned magnitude.
    logic                 op1_neg;
    logic                 op2_neg;
    logic [WIDTH-1:0]     op1_mag;
    logic [WIDTH-1:0]     op2_mag;

    // Restoring step: the trial subtraction is done one bit wider so the
    // borrow (bit WIDTH) tells whether the divisor fit.
    logic [WIDTH:0]       diff;

    // Fix-up: sign correction applied to the raw unsigned results.
    logic [WIDTH-1:0]     quot_raw;
    logic [WIDTH-1:0]     rem_raw;
    logic [WIDTH-1:0]     quot_fix;
    logic [WIDTH-1:0]     rem_fix;

    // Operand conditioning for the accept cycle.
    always_comb begin
        op1_neg = signed_div & opdata1[WIDTH-1];
        op2_neg = signed_div & opdata2[WIDTH-1];
        op1_mag = op1_neg ? (~opdata1 + 1'b1) : opdata1;
        op2_mag = op2_neg ? (~opdata2 + 1'b1) : opdata2;
    end

    // Datapath: trial subtraction and final sign correction.
    always_comb begin
        diff     = {1'b0, dividend_reg[2*WIDTH-1:WIDTH]} - {1'b0, divisor_reg};
        quot_raw = dividend_reg[WIDTH-1:0];
        rem_raw  = dividend_reg[2*WIDTH:WIDTH+1];
        quot_fix = (signed_reg && (sign1_reg ^ sign2_reg)) ? (~quot_raw + 1'b1) : quot_raw;
        rem_fix  = (signed_reg && sign1_reg) ? (~rem_raw + 1'b1) : rem_raw;
    end

    // Next-state and register update logic for the divider FSM.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        dividend_next = dividend_reg;
        divisor_next  = divisor_reg;
        signed_next   = signed_reg;
        sign1_next    = sign1_reg;
        sign2_next    = sign2_reg;
        result_next   = result_reg;
        ready_next    = ready_reg;

        case (state_reg)
            ST_IDLE: begin
                ready_next  = 1'b0;
                result_next = '0;
                if (start && !annul) begin
                    if (opdata2 == '0) begin
                        state_next = ST_BYZERO;
                    end else begin
                        state_next    = ST_ON;
                        cnt_next      = '0;
                        signed_next   = signed_div;
                        sign1_next    = op1_neg;
                        sign2_next    = op2_neg;
                        divisor_next  = op2_mag;
                        dividend_next = {{WIDTH{1'b0}}, op1_mag, 1'b0};
                    end
                end
            end

            ST_BYZERO: begin
                // annul is deliberately ignored here; the 0/0 result is
                // cheap and always completes on the next edge.
                dividend_next = '0;
                result_next   = '0;
                ready_next    = 1'b1;
                state_next    = ST_END;
            end

            ST_ON: begin
                if (annul) begin
                    state_next  = ST_IDLE;
                    result_next = '0;
                    ready_next  = 1'b0;
                end else if (cnt_reg != CNT_DONE) begin
                    if (diff[WIDTH]) begin
                        dividend_next = {dividend_reg[2*WIDTH-1:0], 1'b0};
                    end else begin
                        dividend_next = {diff[WIDTH-1:0], dividend_reg[WIDTH-1:0], 1'b1};
                    end
                    cnt_next = cnt_reg + 6'd1;
                end else begin
                    result_next = {rem_fix, quot_fix};
                    ready_next  = 1'b1;
                    state_next  = ST_END;
                end
            end

            ST_END: begin
                // Result is held until EX drops start; a start held high
                // here never re-arms the unit.
                if (!start) begin
                    state_next  = ST_IDLE;
                    ready_next  = 1'b0;
                    result_next = '0;
                end
            end

            default: begin
                state_next  = ST_IDLE;
                ready_next  = 1'b0;
                result_next = '0;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            dividend_reg <= '0;
            divisor_reg  <= '0;
            signed_reg   <= 1'b0;
            sign1_reg    <= 1'b0;
            sign2_reg    <= 1'b0;
            result_reg   <= '0;
            ready_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            dividend_reg <= dividend_next;
            divisor_reg  <= divisor_next;
            signed_reg   <= signed_next;
            sign1_reg    <= sign1_next;
            sign2_reg    <= sign2_next;
            result_reg   <= result_next;
            ready_reg    <= ready_next;
        end
    end

    // Stall request: asserted combinationally as soon as an operation is
    // requested, released in END so EX advances in the ready cycle.
    always_comb begin
        stallreq = ((state_reg == ST_IDLE) && start && !annul)
                 || (state_reg == ST_BYZERO)
                 || (state_reg == ST_ON);
    end

    assign result = result_reg;
    assign ready  = ready_reg;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;
    logic        stallreq;

    int checks = 0;
    int errors = 0;

    div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .signed_div (signed_div),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .start      (start),
        .annul      (annul),
        .result     (result),
        .ready      (ready),
        .stallreq   (stallreq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run one full operation from IDLE, called #1 after a rising edge.
    task automatic run_op(input string tag, input logic sd, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_q,
                          input logic [31:0] exp_r, input int exp_cycles);
        int  stalls;
        int  edges;
        bit  done;
        logic [63:0] held;
        signed_div = sd;
        opdata1    = a;
        opdata2    = b;
        start      = 1'b1;
        stalls     = 0;
        edges      = 0;
        done       = 1'b0;
        while (!done && edges < 100) begin
            #1;
            if (stallreq) stalls++;
            @(posedge clk);
            #1;
            edges++;
            if (ready) done = 1'b1;
        end
        check({tag, ".ready_seen"}, 64'(done), 64'd1);
        check({tag, ".edges"}, 64'(edges), 64'(exp_cycles));
        check({tag, ".stall_cycles"}, 64'(stalls), 64'(exp_cycles));
        check({tag, ".result"}, result, {exp_r, exp_q});
        check({tag, ".stall_in_end"}, 64'(stallreq), 64'd0);
        held = result;
        // start held high in END must neither restart nor disturb the result
        tick();
        tick();
        check({tag, ".hold_ready"}, 64'(ready), 64'd1);
        check({tag, ".hold_result"}, result, held);
        start = 1'b0;
        #1;
        check({tag, ".stall_release"}, 64'(stallreq), 64'd0);
        tick();
        check({tag, ".idle_ready"}, 64'(ready), 64'd0);
        check({tag, ".idle_result"}, result, 64'd0);
        $display("op %s sd=%0d a=0x%08h b=0x%08h q=0x%08h r=0x%08h cycles=%0d",
                 tag, sd, a, b, held[31:0], held[63:32], edges);
    endtask

    initial begin
        rst        = 1'b0;
        signed_div = 1'b0;
        opdata1    = '0;
        opdata2    = '0;
        start      = 1'b0;
        annul      = 1'b0;

        // Reset state
        tick();
        tick();
        check("reset.ready", 64'(ready), 64'd0);
        check("reset.result", result, 64'd0);
        check("reset.stallreq", 64'(stallreq), 64'd0);
        rst = 1'b1;
        tick();
        check("idle.ready", 64'(ready), 64'd0);
        $display("step reset released");

        // Main function
        run_op("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 34);
        run_op("s-7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 34);
        run_op("s7_-2", 1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 34);
        run_op("u_div0", 1'b0, 32'd1234, 32'd0, 32'd0, 32'd0, 2);
        run_op("s_div0", 1'b1, 32'hFFFFFF00, 32'd0, 32'd0, 32'd0, 2);
        run_op("s_min_-1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 34);
        run_op("u_max_1", 1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 34);

        // annul in IDLE blocks acceptance
        signed_div = 1'b0;
        opdata1    = 32'd9;
        opdata2    = 32'd3;
        start      = 1'b1;
        annul      = 1'b1;
        #1;
        check("idle_annul.stall", 64'(stallreq), 64'd0);
        tick();
        tick();
        check("idle_annul.ready", 64'(ready), 64'd0);
        check("idle_annul.stall2", 64'(stallreq), 64'd0);
        start = 1'b0;
        annul = 1'b0;
        tick();
        $display("step annul-in-idle blocked acceptance");

        // annul at cnt=10
        begin
            int rdy_seen;
            rdy_seen   = 0;
            opdata1    = 32'd100;
            opdata2    = 32'd7;
            start      = 1'b1;
            for (int i = 0; i < 11; i++) begin   // E0..E10 -> cnt = 10
                tick();
                if (ready) rdy_seen++;
            end
            annul = 1'b1;
            tick();
            if (ready) rdy_seen++;
            check("annul.ready", 64'(ready), 64'd0);
            check("annul.result", result, 64'd0);
            check("annul.stall_idle", 64'(stallreq), 64'd0);
            start = 1'b0;
            annul = 1'b0;
            for (int i = 0; i < 40; i++) begin
                tick();
                if (ready) rdy_seen++;
            end
            check("annul.never_ready", 64'(rdy_seen), 64'd0);
            $display("step annul at cnt=10 dropped operation");
        end
        run_op("u9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 34);

        // reset at cnt=20
        opdata1 = 32'd100;
        opdata2 = 32'd7;
        start   = 1'b1;
        for (int i = 0; i < 21; i++) tick();   // E0..E20 -> cnt = 20
        check("pre_rst.stall", 64'(stallreq), 64'd1);
        rst   = 1'b0;
        start = 1'b0;
        #1;
        check("mid_rst.ready", 64'(ready), 64'd0);
        check("mid_rst.result", result, 64'd0);
        check("mid_rst.stall", 64'(stallreq), 64'd0);
        tick();
        rst = 1'b1;
        tick();
        check("post_rst.ready", 64'(ready), 64'd0);
        $display("step reset at cnt=20 returned to idle");
        run_op("u50_5", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 34);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative 32-bit radix-2 divider in the EX stage, directly upstream of the pipeline stall controller. EX hands it operands and a start request for DIV/DIVU. It holds the pipeline through `stallreq`, which drives the controller's `ex_stallsignal` input, until a 64-bit `{remainder, quotient}` result is ready. One restoring-division step per cycle; divide-by-zero and annulment are handled in hardware.

## Interface
- `WIDTH`, 32, operand width; result is 2*WIDTH bits.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous reset, active-low.
- `signed_div`  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with `start` in IDLE.
- `opdata1`  in  32  dividend; sampled with `start` in IDLE.
- `opdata2`  in  32  divisor; sampled with `start` in IDLE.
- `start`  in  1  level request from EX; held high until `ready` is seen.
- `annul`  in  1  abort; in-flight operation is dropped.
- `result`  out  64  `[31:0]` quotient, `[63:32]` remainder; valid while `ready`=1.
- `ready`  out  1  result valid.
- `stallreq`  out  1  to the controller's `ex_stallsignal`; 1 = freeze PC/IF/ID/EX.

## Operation
- States: IDLE, BYZERO, ON, END. Internal regs: `cnt[5:0]`, 65-bit `dividend` shift register, `divisor[31:0]`, latched `signed_div`, latched sign bits of both operands.
- IDLE:
  - `start`=1 and `annul`=0 and `opdata2`=0 -> BYZERO.
  - `start`=1 and `annul`=0 and `opdata2`!=0 -> ON, `cnt`=0.
  - Signed mode loads the two's-complement magnitude of each negative operand.
  - `dividend` = {32'b0, |op1|, 1'b0}.
  - Otherwise stay in IDLE with `ready`=0 and `result`=0.
- BYZERO: `dividend` cleared -> END next edge. Result 0/0.
- ON, `cnt`<32, one step per cycle:
  - `diff` = `dividend[63:32]` - `divisor` (33-bit).
  - If `diff` is negative: `dividend` <= `dividend`<<1.
  - Else: `dividend` <= {`diff[31:0]`, `dividend[31:0]`, 1'b1}.
  - `cnt`++.
- ON, `cnt`==32, fix-up:
  - Quotient = `dividend[31:0]`, negated if signed and operand signs differ.
  - Remainder = `dividend[64:33]`, negated if signed and dividend negative.
  - Load `result`, `ready`=1 -> END.
- ON with `annul`=1, any `cnt`: -> IDLE, `result`=0, `ready`=0.
- END: hold `result` and `ready`=1 while `start`=1. `start`=0 -> IDLE, `ready`=0, `result`=0.
- `stallreq` (combinational) = (IDLE & `start` & ~`annul`) | BYZERO | ON. It is 0 in END, so EX advances in the `ready` cycle.
- Arithmetic corner: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0 (no trap).
- Reset (any state, mid-operation included): state IDLE, `cnt`=0, `result`=0, `ready`=0, `stallreq` = 0 while `start`=0.

## Timing
- Start-up edges:
  - E0 = first edge with `start`=1 in IDLE.
  - Nonzero divisor: iterations on E1..E32, fix-up on E33. `ready`=1 from after E33 until `start` drops.
  - Zero divisor: BYZERO after E0, END after E1.
- Busy time: `stallreq` high combinationally from the cycle `start` rises. It stays high through the cycle ending at E33 (E1 for divide-by-zero).
- Result capture: EX samples `result` at the edge after `ready` rises. It then deasserts `start`, and the unit returns to IDLE one edge later.
- Back-to-back: a new operation is accepted only from IDLE. `start` held continuously high in END does not restart.
- `annul` in IDLE blocks acceptance. In BYZERO it is ignored. In END it has no effect.

## Test plan
- Unsigned 100 / 7 -> after E33 `ready`=1, `result` = {32'd2, 32'd14}; `stallreq` high for exactly 34 cycles.
- Signed -7 / 2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1); signed 7 / -2 -> quotient -3, remainder 1.
- Divisor 0, either mode -> `ready` after E1, `result`=0, `stallreq` high 2 cycles.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0; unsigned 0xFFFFFFFF / 1 -> quotient 0xFFFFFFFF, remainder 0.
- `annul` at `cnt`=10 -> IDLE next edge, `ready` never asserts, `result`=0. A new 9 / 3 then completes with quotient 3, remainder 0.
- `rst` low at `cnt`=20 -> immediate IDLE, all outputs 0. After release, 50 / 5 completes with quotient 10, remainder 0.
